// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the 16-bit CPU.
// Holds the PC, requests instruction words over a req/valid handshake and
// latches them into the instruction register (IR). The IR is sliced into the
// opcode / reg_sel / immed fields that feed decode and sign-extend.
//
// Handshakes:
//   memory : a word is taken on any cycle where mem_req=1 and mem_valid=1.
//            mem_valid while mem_req=0 (e.g. after a redirect or in HOLD)
//            is ignored.
//   decode : the IR is consumed on any cycle where ir_valid=1 and stall=0.
//
// Optional feature macro: PREFETCH_BUF_EN
//   When defined, a one-entry prefetch buffer keeps fetching while decode
//   stalls, so the next word moves into the IR with no bubble on release.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ir_valid,
    output logic [5:0]  opcode,
    output logic        reg_sel,
    output logic [8:0]  immed,
    output logic [15:0] pc_out,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [15:0] STEP = 16'(PC_STEP);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_pc_out;
    logic        r_ir_valid;
    logic        w_mem_req;
    logic        w_take;
    logic        w_ir_free;

`ifdef PREFETCH_BUF_EN
    logic [15:0] r_buf_data;
    logic [15:0] r_buf_pc;
    logic        r_buf_valid;
`else
    logic        w_consume;
    assign w_consume = r_ir_valid & ~stall;
`endif

    // IR may accept a new word: it is empty or being consumed this cycle
    assign w_ir_free = ~r_ir_valid | ~stall;
    // A word is taken only while a request is actually on the bus
    assign w_take    = w_mem_req & mem_valid;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; redirect overrides every state
    always_comb begin
        w_next_state = r_state;
        if (redirect) begin
            w_next_state = S_REQ;
        end else begin
            case (r_state)
                S_IDLE: w_next_state = S_REQ;
                S_REQ: begin
`ifdef PREFETCH_BUF_EN
                    // the buffer absorbs stalls, so fetching never parks
                    w_next_state = S_REQ;
`else
                    if (stall && (r_ir_valid || w_take)) begin
                        w_next_state = S_HOLD;
                    end
`endif
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_next_state = S_REQ;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // FSM outputs: request only in REQ, dropped combinationally on redirect
    always_comb begin
        w_mem_req = 1'b0;
        if (r_state == S_REQ && !redirect) begin
`ifdef PREFETCH_BUF_EN
            w_mem_req = ~r_buf_valid;
`else
            w_mem_req = w_ir_free;
`endif
        end
    end

    // PC, IR and (optionally) prefetch buffer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_ir       <= 16'h0000;
            r_pc_out   <= RESET_PC;
            r_ir_valid <= 1'b0;
`ifdef PREFETCH_BUF_EN
            r_buf_data  <= 16'h0000;
            r_buf_pc    <= RESET_PC;
            r_buf_valid <= 1'b0;
`endif
        end else if (redirect) begin
            // squash the IR, any buffered word and any fetch in flight
            r_pc       <= redirect_pc;
            r_ir_valid <= 1'b0;
`ifdef PREFETCH_BUF_EN
            r_buf_valid <= 1'b0;
`endif
        end else begin
`ifdef PREFETCH_BUF_EN
            if (w_take) begin
                r_pc <= r_pc + STEP;
            end
            if (w_ir_free) begin
                if (r_buf_valid) begin
                    r_ir        <= r_buf_data;
                    r_pc_out    <= r_buf_pc;
                    r_ir_valid  <= 1'b1;
                    r_buf_valid <= 1'b0;
                end else if (w_take) begin
                    r_ir       <= mem_rdata;
                    r_pc_out   <= r_pc;
                    r_ir_valid <= 1'b1;
                end else begin
                    r_ir_valid <= 1'b0;
                end
            end else if (w_take) begin
                r_buf_data  <= mem_rdata;
                r_buf_pc    <= r_pc;
                r_buf_valid <= 1'b1;
            end
`else
            if (w_take) begin
                r_ir       <= mem_rdata;
                r_pc_out   <= r_pc;
                r_pc       <= r_pc + STEP;
                r_ir_valid <= 1'b1;
            end else if (w_consume) begin
                r_ir_valid <= 1'b0;
            end
`endif
        end
    end

    assign mem_req   = w_mem_req;
    assign mem_addr  = r_pc;
    assign ir_valid  = r_ir_valid;
    assign opcode    = r_ir[15:10];
    assign reg_sel   = r_ir[9];
    assign immed     = r_ir[8:0];
    assign pc_out    = r_pc_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit.
// Expected {pc_out, IR} pairs are pushed when a memory word is driven and
// popped when the fetch unit presents it.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        ir_valid;
    logic [5:0]  opcode;
    logic        reg_sel;
    logic [8:0]  immed;
    logic [15:0] pc_out;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    logic [15:0] exp_pc;
    logic [31:0] exp_w;
    int          n_checks = 0;
    int          n_pass = 0;

    instr_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .opcode(opcode), .reg_sel(reg_sel), .immed(immed),
        .pc_out(pc_out), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // reset and leave the DUT in REQ, returning at a falling edge
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_valid = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; mem_rdata = 16'h0000;
        exp_q.delete();
        exp_pc = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // drive one memory word for the current request; returns 1ns after the edge
    task automatic drive_fetch(input logic [15:0] word);
        mem_valid = 1'b1;
        mem_rdata = word;
        exp_q.push_back({exp_pc, word});
        exp_pc = exp_pc + 16'd1;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_pc = 16'h0000;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else n_pass++;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL reset_ir_valid: got %b want 0", ir_valid); else n_pass++;
        n_checks++; if (pc_out !== 16'h0000) $display("FAIL reset_pc_out: got %h want 0000", pc_out); else n_pass++;
        n_checks++; if ({opcode, reg_sel, immed} !== 16'h0000) $display("FAIL reset_ir: got %h want 0000", {opcode, reg_sel, immed}); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
        n_checks++; if (mem_addr !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", mem_addr); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || dbg_state !== 2'd0) $display("FAIL idle_after_release: req=%b state=%0d want 0/0", mem_req, dbg_state); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || dbg_state !== 2'd1) $display("FAIL first_req: req=%b addr=%h state=%0d want 1/0000/1", mem_req, mem_addr, dbg_state); else n_pass++;
    endtask

    task automatic test_first_fetch();
        drive_fetch(16'hFC05);
        n_checks++; if (ir_valid !== 1'b1) $display("FAIL ff_ir_valid: got %b want 1", ir_valid); else n_pass++;
        n_checks++; if (opcode !== 6'h3F) $display("FAIL ff_opcode: got %h want 3f", opcode); else n_pass++;
        n_checks++; if (reg_sel !== 1'b0) $display("FAIL ff_reg_sel: got %b want 0", reg_sel); else n_pass++;
        n_checks++; if (immed !== 9'h005) $display("FAIL ff_immed: got %h want 005", immed); else n_pass++;
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w) $display("FAIL ff_scoreboard: got %h want %h", {pc_out, opcode, reg_sel, immed}, exp_w); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) $display("FAIL ff_next_pc: req=%b addr=%h want 1/0001", mem_req, mem_addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] words[3];
        logic [8:0]  imms[3];
        words = '{16'h0001, 16'h0100, 16'h01FF};
        imms  = '{9'h001, 9'h100, 9'h1FF};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'(i)) $display("FAIL b2b_addr%0d: req=%b addr=%h want 1/%h", i, mem_req, mem_addr, 16'(i)); else n_pass++;
            drive_fetch(words[i]);
            n_checks++; if (ir_valid !== 1'b1 || immed !== imms[i]) $display("FAIL b2b_immed%0d: valid=%b immed=%h want 1/%h", i, ir_valid, immed, imms[i]); else n_pass++;
            if (exp_q.size() == 0) begin
                n_checks++; $display("FAIL b2b_sb%0d: got empty queue want entry", i);
            end else begin
                exp_w = exp_q.pop_front();
                n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w) $display("FAIL b2b_sb%0d: got %h want %h", i, {pc_out, opcode, reg_sel, immed}, exp_w); else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic exp_req;
        apply_reset();
        #1;
        drive_fetch(16'h1234);
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w || ir_valid !== 1'b1) $display("FAIL stall_first: got %h/%b want %h/1", {pc_out, opcode, reg_sel, immed}, ir_valid, exp_w); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            #1;
`ifdef PREFETCH_BUF_EN
            exp_req = (i == 0);
`else
            exp_req = 1'b0;
`endif
            n_checks++; if (mem_req !== exp_req) $display("FAIL stall_req%0d: got %b want %b", i, mem_req, exp_req); else n_pass++;
            n_checks++; if (ir_valid !== 1'b1 || {opcode, reg_sel, immed} !== 16'h1234 || pc_out !== 16'h0000) $display("FAIL stall_ir%0d: got %b/%h/%h want 1/1234/0000", i, ir_valid, {opcode, reg_sel, immed}, pc_out); else n_pass++;
            if (exp_req) begin
                n_checks++; if (mem_addr !== 16'h0001) $display("FAIL stall_pf_addr: got %h want 0001", mem_addr); else n_pass++;
                mem_valid = 1'b1;
                mem_rdata = 16'h5678;
                exp_q.push_back({exp_pc, 16'h5678});
                exp_pc = exp_pc + 16'd1;
            end else if (i == 2) begin
                // unrequested strobe must be ignored
                mem_valid = 1'b1;
                mem_rdata = 16'hDEAD;
            end
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
        end
`ifndef PREFETCH_BUF_EN
        n_checks++; if (dbg_state !== 2'd2) $display("FAIL stall_hold_state: got %0d want 2", dbg_state); else n_pass++;
`endif
        @(negedge clk);
        stall = 1'b0;
        #1;
`ifdef PREFETCH_BUF_EN
        n_checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b1) $display("FAIL stall_pf_release: req=%b valid=%b want 0/1", mem_req, ir_valid); else n_pass++;
        @(posedge clk);
        #1;
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w || ir_valid !== 1'b1) $display("FAIL stall_pf_nobubble: got %h/%b want %h/1", {pc_out, opcode, reg_sel, immed}, ir_valid, exp_w); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) $display("FAIL stall_pf_resume: req=%b addr=%h want 1/0002", mem_req, mem_addr); else n_pass++;
`else
        n_checks++; if (mem_req !== 1'b0) $display("FAIL stall_release_req: got %b want 0", mem_req); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL stall_consumed: got %b want 0", ir_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) $display("FAIL stall_resume: req=%b addr=%h want 1/0001", mem_req, mem_addr); else n_pass++;
        drive_fetch(16'h5678);
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w || ir_valid !== 1'b1) $display("FAIL stall_after: got %h/%b want %h/1", {pc_out, opcode, reg_sel, immed}, ir_valid, exp_w); else n_pass++;
`endif
    endtask

    task automatic test_redirect();
        apply_reset();
        #1;
        drive_fetch(16'h1111);
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w) $display("FAIL rd_first: got %h want %h", {pc_out, opcode, reg_sel, immed}, exp_w); else n_pass++;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rdata = 16'hAAAA;
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rd_req_drop: got %b want 0", mem_req); else n_pass++;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        redirect = 1'b0;
        exp_pc = 16'h0040;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL rd_ir_valid: got %b want 0", ir_valid); else n_pass++;
        n_checks++; if ({opcode, reg_sel, immed} === 16'hAAAA) $display("FAIL rd_squash: got %h want not aaaa", {opcode, reg_sel, immed}); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040) $display("FAIL rd_target: req=%b addr=%h want 1/0040", mem_req, mem_addr); else n_pass++;
        drive_fetch(16'h2222);
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w || ir_valid !== 1'b1) $display("FAIL rd_fetch: got %h/%b want %h/1", {pc_out, opcode, reg_sel, immed}, ir_valid, exp_w); else n_pass++;
        // redirect while decode is stalled flushes the IR
        @(negedge clk);
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        @(posedge clk);
        #1;
        stall = 1'b0;
        redirect = 1'b0;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL rd_stall_flush: got %b want 0", ir_valid); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100) $display("FAIL rd_stall_target: req=%b addr=%h want 1/0100", mem_req, mem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        #1;
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        @(posedge clk);
        #1;
        redirect = 1'b0;
        exp_pc = 16'hFFFF;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) $display("FAIL wrap_addr0: req=%b addr=%h want 1/ffff", mem_req, mem_addr); else n_pass++;
        drive_fetch(16'h0A0A);
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w || pc_out !== 16'hFFFF) $display("FAIL wrap_fetch0: got %h want %h", {pc_out, opcode, reg_sel, immed}, exp_w); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) $display("FAIL wrap_addr1: req=%b addr=%h want 1/0000", mem_req, mem_addr); else n_pass++;
        drive_fetch(16'h0B0B);
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w || pc_out !== 16'h0000) $display("FAIL wrap_fetch1: got %h want %h", {pc_out, opcode, reg_sel, immed}, exp_w); else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        #1;
        drive_fetch(16'h1357);
        exp_w = exp_q.pop_front();
        @(negedge clk);
        #1;
        drive_fetch(16'h2468);
        exp_w = exp_q.pop_front();
        n_checks++; if ({pc_out, opcode, reg_sel, immed} !== exp_w) $display("FAIL rmf_setup: got %h want %h", {pc_out, opcode, reg_sel, immed}, exp_w); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) $display("FAIL rmf_req: req=%b addr=%h want 1/0002", mem_req, mem_addr); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b0) $display("FAIL rmf_async: req=%b valid=%b want 0/0", mem_req, ir_valid); else n_pass++;
        n_checks++; if (mem_addr !== 16'h0000 || pc_out !== 16'h0000 || dbg_state !== 2'd0) $display("FAIL rmf_values: pc=%h pc_out=%h state=%0d want 0000/0000/0", mem_addr, pc_out, dbg_state); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) $display("FAIL rmf_restart: req=%b addr=%h want 1/0000", mem_req, mem_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid_fetch();
        n_checks++; if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d entries want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
